// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SEND  = 2'b01,
        ST_GUARD = 2'b10,
        ST_BUSY  = 2'b11
    } arb_state_t;

    function automatic int unsigned wrap_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte handshake plus transmitter strobe/status, bundled for the arbiter.
interface uart_tx_arbiter_if #(
    parameter int NumRequesters = 2
);
    logic [8*NumRequesters-1:0] req_byte;
    logic [NumRequesters-1:0]   req_valid;
    logic [NumRequesters-1:0]   req_last;
    logic [NumRequesters-1:0]   req_ready;
    logic [7:0]                 tx_byte;
    logic                       tx_byte_valid;
    logic                       tx_byte_done;

    modport slave (
        input  req_byte, req_valid, req_last, tx_byte_done,
        output req_ready, tx_byte, tx_byte_valid
    );

    modport master (
        output req_byte, req_valid, req_last, tx_byte_done,
        input  req_ready, tx_byte, tx_byte_valid
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester at or after i_ptr, wrapping modulo N.
module uart_tx_arbiter_rr_pick #(
    parameter int N  = 2,
    parameter int IW = 3
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);
    int w_best;
    int w_dist;

    // Smallest forward distance from the pointer wins.
    always_comb begin
        w_best  = N;
        w_dist  = 0;
        o_idx   = '0;
        o_grant = '0;
        for (int j = 0; j < N; j++) begin
            w_dist = (j >= int'(i_ptr)) ? j - int'(i_ptr) : j + N - int'(i_ptr);
            if (i_req[j] && (w_dist < w_best)) begin
                w_best = w_dist;
                o_idx  = IW'(j);
            end
        end
        o_any = (w_best < N);
        for (int j = 0; j < N; j++) begin
            o_grant[j] = o_any && (o_idx == IW'(j));
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NumRequesters byte producers, round-robin with packet lock.
//   state | meaning
//   IDLE  | transmitter idle, accept a byte from the candidate requester
//   SEND  | one-cycle tx_byte_valid strobe
//   GUARD | ignore tx_byte_done while the transmitter drops it
//   BUSY  | wait for tx_byte_done
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NumRequesters = 2,
    parameter int IdWidth       = 3
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    uart_tx_arbiter_if.slave   bus,
    output logic [IdWidth-1:0] o_grant_id,
    output logic               o_locked
);
    arb_state_t               r_state;
    logic [IdWidth-1:0]       r_ptr;
    logic [IdWidth-1:0]       r_grant_id;
    logic                     r_locked;
    logic [7:0]               r_tx_byte;
    logic                     r_tx_valid;

    logic [NumRequesters-1:0] w_rr_grant;
    logic [IdWidth-1:0]       w_rr_idx;
    logic                     w_rr_any;
    logic [NumRequesters-1:0] w_lock_grant;
    logic [NumRequesters-1:0] w_pick_grant;
    logic [IdWidth-1:0]       w_pick_idx;
    logic                     w_pick_any;
    logic [7:0]               w_pick_byte;
    logic                     w_pick_last;
    logic [IdWidth-1:0]       w_next_ptr;
    logic                     w_accept;

    uart_tx_arbiter_rr_pick #(
        .N  (NumRequesters),
        .IW (IdWidth)
    ) u_rr_pick (
        .i_req   (bus.req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_rr_grant),
        .o_idx   (w_rr_idx),
        .o_any   (w_rr_any)
    );

    // While locked only the owner may be picked; otherwise the round-robin choice stands.
    always_comb begin
        w_lock_grant = '0;
        w_pick_byte  = 8'h00;
        w_pick_last  = 1'b0;
        for (int k = 0; k < NumRequesters; k++) begin
            w_lock_grant[k] = bus.req_valid[k] && (r_grant_id == IdWidth'(k));
        end
        w_pick_grant = r_locked ? w_lock_grant : w_rr_grant;
        w_pick_idx   = r_locked ? r_grant_id : w_rr_idx;
        w_pick_any   = r_locked ? (|w_lock_grant) : w_rr_any;
        for (int k = 0; k < NumRequesters; k++) begin
            if (w_pick_grant[k]) begin
                w_pick_byte = bus.req_byte[8*k +: 8];
                w_pick_last = bus.req_last[k];
            end
        end
    end

    assign w_next_ptr = IdWidth'(wrap_next(32'(w_pick_idx), NumRequesters));

    // Reset gates the combinational ready so nothing is consumed while held in reset.
    assign w_accept = i_rst_n && (r_state == ST_IDLE) && bus.tx_byte_done && w_pick_any;

    assign bus.req_ready     = w_accept ? w_pick_grant : '0;
    assign bus.tx_byte       = r_tx_byte;
    assign bus.tx_byte_valid = r_tx_valid;
    assign o_grant_id        = r_grant_id;
    assign o_locked          = r_locked;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_grant_id <= '0;
            r_locked   <= 1'b0;
            r_tx_byte  <= 8'h00;
            r_tx_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_tx_byte  <= w_pick_byte;
                        r_grant_id <= w_pick_idx;
                        r_tx_valid <= 1'b1;
                        r_state    <= ST_SEND;
                        if (w_pick_last) begin
                            r_locked <= 1'b0;
                            r_ptr    <= w_next_ptr;
                        end else begin
                            r_locked <= 1'b1;
                        end
                    end
                end
                ST_SEND: begin
                    r_tx_valid <= 1'b0;
                    r_state    <= ST_GUARD;
                end
                ST_GUARD: begin
                    r_state <= ST_BUSY;
                end
                ST_BUSY: begin
                    if (bus.tx_byte_done) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_tx_valid <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized and directed bench for uart_tx_arbiter with a transmitter stand-in and a packet-level model.
module tb_uart_tx_arbiter;
    localparam int NREQ = 3;
    localparam int IDW  = 2;
    localparam int MAXQ = 32;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic [IDW-1:0] grant_id;
    logic           locked;

    int         cyc       = 0;
    int         frame_len = 1;
    int         stub_cnt  = 0;
    int         tx_cnt    = 0;
    logic [7:0] tx_log [256];

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] drv_data  [NREQ][MAXQ];
    logic       drv_last  [NREQ][MAXQ];
    int         drv_delay [NREQ][MAXQ];
    int         drv_len   [NREQ];
    int         drv_pos   [NREQ];
    int         drv_wait  [NREQ];

    int         exp_req   [$];
    logic [7:0] exp_data  [$];
    logic       exp_last  [$];
    int         exp_delay [$];

    uart_tx_arbiter_if #(.NumRequesters(NREQ)) bus ();

    uart_tx_arbiter #(
        .NumRequesters (NREQ),
        .IdWidth       (IDW)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .bus        (bus),
        .o_grant_id (grant_id),
        .o_locked   (locked)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter stand-in: done drops for frame_len cycles after each strobe; frame_len 0 never drops it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.tx_byte_done <= 1'b1;
            stub_cnt         <= 0;
            tx_cnt           <= 0;
        end else if (bus.tx_byte_valid) begin
            tx_log[tx_cnt[7:0]] <= bus.tx_byte;
            tx_cnt              <= tx_cnt + 1;
            if (frame_len > 0) begin
                bus.tx_byte_done <= 1'b0;
                stub_cnt         <= frame_len;
            end
        end else if (stub_cnt > 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1) bus.tx_byte_done <= 1'b1;
        end
    end

    task automatic check_val(input string tag, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        int idx;
        idx = -1;
        for (int k = 0; k < NREQ; k++) if (v[k]) idx = k;
        return idx;
    endfunction

    task automatic clear_reqs();
        for (int r = 0; r < NREQ; r++) begin
            drv_len[r]  = 0;
            drv_pos[r]  = 0;
            drv_wait[r] = 0;
        end
    endtask

    task automatic add_item(input int r, input logic [7:0] d, input logic last, input int delay);
        drv_data[r][drv_len[r]]  = d;
        drv_last[r][drv_len[r]]  = last;
        drv_delay[r][drv_len[r]] = delay;
        drv_len[r]++;
    endtask

    task automatic drive_reqs();
        for (int r = 0; r < NREQ; r++) begin
            if (drv_pos[r] < drv_len[r]) begin
                bus.req_valid[r]        = (drv_wait[r] == 0);
                bus.req_byte[8*r +: 8]  = drv_data[r][drv_pos[r]];
                bus.req_last[r]         = drv_last[r][drv_pos[r]];
            end else begin
                bus.req_valid[r]        = 1'b0;
                bus.req_byte[8*r +: 8]  = 8'h00;
                bus.req_last[r]         = 1'b0;
            end
        end
    endtask

    task automatic advance_reqs(input logic [NREQ-1:0] hs);
        for (int r = 0; r < NREQ; r++) begin
            if (hs[r]) begin
                drv_pos[r]++;
                drv_wait[r] = (drv_pos[r] < drv_len[r]) ? drv_delay[r][drv_pos[r]] : 0;
            end else if (drv_wait[r] > 0) begin
                drv_wait[r]--;
            end
        end
        drive_reqs();
    endtask

    // Packet-level model: whole packets, next non-empty requester at or after the pointer.
    task automatic build_expected();
        int pos [NREQ];
        int ptr;
        int remaining;
        int r;
        logic pkt_end;
        exp_req.delete();
        exp_data.delete();
        exp_last.delete();
        exp_delay.delete();
        ptr = 0;
        remaining = 0;
        for (int i = 0; i < NREQ; i++) begin
            pos[i] = 0;
            remaining += drv_len[i];
        end
        while (remaining > 0) begin
            r = -1;
            for (int k = 0; k < NREQ; k++) begin
                if (r < 0 && pos[(ptr + k) % NREQ] < drv_len[(ptr + k) % NREQ]) r = (ptr + k) % NREQ;
            end
            pkt_end = 1'b0;
            while (!pkt_end && pos[r] < drv_len[r]) begin
                exp_req.push_back(r);
                exp_data.push_back(drv_data[r][pos[r]]);
                exp_last.push_back(drv_last[r][pos[r]]);
                exp_delay.push_back(drv_delay[r][pos[r]]);
                pkt_end = drv_last[r][pos[r]];
                pos[r]++;
                remaining--;
            end
            ptr = (r + 1) % NREQ;
        end
    endtask

    task automatic run_scenario(input string name, input int flen);
        int         hs_idx;
        int         exp_cyc;
        int         period;
        int         drain;
        int         w;
        logic       prev_hs;
        logic [7:0] prev_byte;
        int         prev_req;
        logic       prev_last;
        logic [NREQ-1:0] hs;
        frame_len = flen;
        build_expected();
        for (int r = 0; r < NREQ; r++) begin
            drv_pos[r]  = 0;
            drv_wait[r] = (drv_len[r] > 0) ? drv_delay[r][0] : 0;
        end
        drive_reqs();
        rst_n = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_val({name, " rst ready"}, bus.req_ready, 0);
        check_val({name, " rst tx_byte"}, bus.tx_byte, 0);
        check_val({name, " rst tx_valid"}, bus.tx_byte_valid, 0);
        check_val({name, " rst grant_id"}, grant_id, 0);
        check_val({name, " rst locked"}, locked, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        hs_idx    = 0;
        exp_cyc   = cyc;
        period    = ((flen < 1) ? 1 : flen) + 3;
        drain     = -1;
        prev_hs   = 1'b0;
        prev_byte = 8'h00;
        prev_req  = 0;
        prev_last = 1'b1;
        for (int k = 0; k < 4000 && drain != 0; k++) begin
            @(negedge clk);
            check_val({name, " tx_valid"}, bus.tx_byte_valid, prev_hs);
            if (prev_hs) begin
                check_val($sformatf("%s tx_byte #%0d", name, hs_idx - 1), bus.tx_byte, prev_byte);
                check_val($sformatf("%s grant_id #%0d", name, hs_idx - 1), grant_id, prev_req);
                check_val($sformatf("%s locked #%0d", name, hs_idx - 1), locked, !prev_last);
            end
            hs      = bus.req_ready;
            prev_hs = (hs != 0);
            if (hs != 0) begin
                check_val({name, " ready onehot"}, $onehot(hs), 1);
                if (hs_idx < exp_req.size()) begin
                    w = onehot_idx(hs);
                    check_val($sformatf("%s winner #%0d", name, hs_idx), w, exp_req[hs_idx]);
                    if (exp_delay[hs_idx] == 0)
                        check_val($sformatf("%s hs cycle #%0d", name, hs_idx), cyc, exp_cyc);
                    prev_byte = exp_data[hs_idx];
                    prev_req  = exp_req[hs_idx];
                    prev_last = exp_last[hs_idx];
                    hs_idx++;
                    exp_cyc = cyc + period;
                end else begin
                    check_val({name, " extra handshake"}, hs, 0);
                end
            end
            @(posedge clk);
            #1;
            advance_reqs(hs);
            if (hs_idx == exp_req.size() && drain < 0) drain = period + 3;
            else if (drain > 0) drain--;
        end
        check_val({name, " handshakes"}, hs_idx, exp_req.size());
        check_val({name, " bytes sent"}, tx_cnt, exp_req.size());
        for (int i = 0; i < exp_req.size() && i < tx_cnt; i++) begin
            check_val($sformatf("%s uart byte #%0d", name, i), tx_log[i[7:0]], exp_data[i]);
        end
    endtask

    task automatic reset_mid_frame();
        logic found;
        frame_len = 8;
        clear_reqs();
        add_item(1, 8'h21, 1'b0, 0);
        add_item(1, 8'h22, 1'b1, 0);
        drive_reqs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (bus.req_ready[1]) found = 1'b1;
        end
        check_val("midrst first grant", found, 1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_val("midrst locked before", locked, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("midrst locked", locked, 0);
        check_val("midrst tx_byte", bus.tx_byte, 0);
        check_val("midrst tx_valid", bus.tx_byte_valid, 0);
        check_val("midrst grant_id", grant_id, 0);
        check_val("midrst ready", bus.req_ready, 0);
        clear_reqs();
        add_item(0, 8'h5A, 1'b1, 0);
        drive_reqs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 2 && !found; k++) begin
            @(negedge clk);
            if (bus.req_ready != 0) begin
                found = 1'b1;
                check_val("midrst regrant vector", bus.req_ready, 1);
            end
        end
        check_val("midrst regrant within 2", found, 1);
        @(posedge clk);
        #1;
        clear_reqs();
        drive_reqs();
        repeat (12) @(posedge clk);
    endtask

    task automatic gen_random();
        int npk;
        int nb;
        int total;
        clear_reqs();
        total = 0;
        for (int r = 0; r < NREQ; r++) begin
            npk = $urandom_range(0, 3);
            for (int p = 0; p < npk; p++) begin
                nb = $urandom_range(1, 4);
                for (int b = 0; b < nb; b++) begin
                    add_item(r, 8'($urandom_range(0, 255)), (b == nb - 1),
                             (b > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : 0);
                    total++;
                end
            end
        end
        if (total == 0) add_item(0, 8'($urandom_range(0, 255)), 1'b1, 0);
    endtask

    initial begin
        int lens [5];
        lens[0] = 0; lens[1] = 1; lens[2] = 2; lens[3] = 4; lens[4] = 7;
        bus.req_valid = '0;
        bus.req_byte  = '0;
        bus.req_last  = '0;

        clear_reqs();
        add_item(0, 8'h55, 1'b1, 0);
        run_scenario("single", 20);

        clear_reqs();
        add_item(0, 8'hA0, 1'b1, 0); add_item(0, 8'hA0, 1'b1, 0);
        add_item(1, 8'hB1, 1'b1, 0); add_item(1, 8'hB1, 1'b1, 0);
        run_scenario("rr", 2);

        clear_reqs();
        add_item(0, 8'hA0, 1'b1, 0); add_item(0, 8'hA0, 1'b1, 0);
        add_item(1, 8'hB1, 1'b1, 0); add_item(1, 8'hB1, 1'b1, 0);
        run_scenario("rr_degen", 0);

        clear_reqs();
        add_item(0, 8'hFF, 1'b1, 0); add_item(0, 8'hFF, 1'b1, 0);
        add_item(1, 8'h01, 1'b0, 0); add_item(1, 8'h02, 1'b0, 0); add_item(1, 8'h03, 1'b1, 0);
        run_scenario("lock", 1);

        clear_reqs();
        add_item(0, 8'h10, 1'b1, 0); add_item(0, 8'h11, 1'b1, 0);
        add_item(1, 8'h03, 1'b0, 0); add_item(1, 8'h04, 1'b1, 50);
        run_scenario("stall", 3);

        clear_reqs();
        add_item(0, 8'hC0, 1'b1, 0);
        add_item(2, 8'hC2, 1'b1, 0); add_item(2, 8'hC3, 1'b1, 0);
        run_scenario("wrap", 2);

        reset_mid_frame();

        for (int it = 0; it < 10; it++) begin
            gen_random();
            run_scenario($sformatf("rand%0d", it), lens[$urandom_range(0, 4)]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end
endmodule
